spi_boot_loader: RTL and testbench
==================================

# spi_boot_loader

Receives the ROM image that the ARM pushes over SPI at power-up and writes it, byte by byte, into the external SRAM. It sits between the `arm_ss`/`arm_sclk`/`arm_mosi` pins and the SRAM write arbiter. It holds `booting` high so the top level keeps the 6502 in reset until the image is complete.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop stages in the pin synchronisers, minimum 2.
- `ADDR_W`, default 18: SRAM address width. The low `ADDR_W` bits of the 24-bit SPI address are used.

Ports:
- `clk100`, in, 1: system clock, 100 MHz.
- `reset`, in, 1: asynchronous, active-high.
- `arm_ss`, in, 1: SPI slave select, active-low, asynchronous to `clk100`.
- `arm_sclk`, in, 1: SPI clock, asynchronous to `clk100`, up to 20 MHz.
- `arm_mosi`, in, 1: SPI data, asynchronous to `clk100`.
- `wr_req`, out, 1: write request to the SRAM arbiter.
- `wr_addr`, out, `ADDR_W`: write address. Stable while `wr_req` is high.
- `wr_data`, out, 8: write data. Stable while `wr_req` is high.
- `wr_ack`, in, 1: arbiter accepted the write.
- `booting`, out, 1: image not yet loaded. Holds the CPU in reset.
- `error`, out, 1: sticky. Set when a transfer is truncated.
- `overrun`, out, 1: sticky. Set when a byte is dropped because the arbiter was too slow.

## Operation
- Synchronisers:
  - `arm_ss`, `arm_sclk` and `arm_mosi` each pass through `SYNC_STAGES` flops, then one history flop for edge detection.
  - A bit is sampled on the synchronised rising edge of `arm_sclk`, MSB first.
- Shift path:
  - 3-bit bit counter and 8-bit shift register.
  - Both clear on the synchronised falling edge of `arm_ss`.
  - Each completed 8th bit produces a byte event.
- State machine:
  - IDLE: waits for `arm_ss` to fall, then goes to HDR.
  - HDR: collects six byte events into a 3-bit byte index.
    - Bytes 0–2 are the start address, little-endian.
    - Bytes 3–5 are the end address, little-endian.
    - After byte 5: `addr` is loaded with start. If end < start (24-bit unsigned compare), go to DONE; otherwise go to DATA.
  - DATA: on each byte event, present `{addr[ADDR_W-1:0], byte}` on the write port, then increment `addr`. When the written `addr` equals end, go to DONE.
  - DONE: further bytes are ignored. When `arm_ss` rises, `booting` drops to 0 and the state goes to IDLE. The block re-arms, so a later transfer reloads the image.
  - `arm_ss` rising in HDR or DATA sets `error`, returns to IDLE, and leaves `booting` unchanged.
  - `arm_ss` falling in any state other than IDLE restarts HDR with byte index 0.
- Write handshake:
  - `wr_req` rises on the cycle after the byte event.
  - `wr_req` holds until the first cycle on which `wr_ack` is sampled high, then falls on the next edge.
  - `wr_addr` and `wr_data` are registered and stay stable throughout.
  - If a new byte event arrives while `wr_req` is still high, that byte is dropped, `overrun` is set, and `addr` still increments so later bytes land at their correct addresses.
- Address arithmetic: `addr` is 24-bit and wraps modulo 2^24. `wr_addr` is its truncation to `ADDR_W` bits, so SRAM aliasing is intended.

## Timing
- Reset values:
  - Outputs: `booting`=1, `wr_req`=0, `wr_addr`=0, `wr_data`=0, `error`=0, `overrun`=0.
  - Internal: state IDLE, all synchroniser flops at their idle levels (`ss`=1, `sclk`=1, `mosi`=1).
- Latency:
  - Pin edge to internal edge detect: `SYNC_STAGES`+1 cycles.
  - Detected 8th `sclk` edge to `wr_req` high: 1 cycle.
- Sampling margin: each `arm_sclk` phase must be at least 2 `clk100` cycles. 25 ns phases meet this.
- Arbiter deadline: a 20 MHz byte lasts 400 ns (40 cycles), so the arbiter must ack within 38 cycles to avoid an overrun.
- Reset asserted mid-transfer: everything returns to reset values at once, including `booting`=1. No partial write is issued after reset.
- Simultaneous `arm_ss` rise and a byte event in the same cycle: the `ss` rise wins and the byte is discarded.

## Structure
- Package `boot_pkg`:
  - State enum: IDLE, HDR, DATA, DONE.
  - Constant `HDR_BYTES`=6.
  - SPI address width constant = 24.
- Sub-module `sync_edge`: an N-stage synchroniser plus rise/fall pulse outputs, instantiated three times. Rise/fall outputs on the `mosi` instance are unused.

## Test plan
- Load start=0x00C000, end=0x00C003 with data A9 00 8D FF, ack 3 cycles after each request → four writes, to 0x0C000..0x0C003 with A9, 00, 8D, FF. `booting` falls only after `ss` rises. `error`=0 and `overrun`=0.
- Same header, but `ss` raised after 2 data bytes → exactly two writes, `error`=1, `booting` stays 1. A following complete transfer clears `booting`; `error` remains 1.
- `wr_ack` held low for 60 cycles during a 20 MHz stream → the second byte is dropped and `overrun`=1. The third byte is written at start+2.
- end=0x00BFFF, start=0x00C000 → zero writes. `booting` falls on `ss` rise. `error`=0.
- start=0x03FFFF, end=0x040000 with bytes 11 22 → `wr_addr` 0x3FFFF then 0x00000 (18-bit alias).
- `reset` pulsed during the DATA phase → all outputs return to reset values, including `booting`=1 and `wr_req`=0. A subsequent clean transfer completes normally.

Source files
------------

// File: rtl/spi_boot_loader_pkg.sv
// Shared types and constants for the SPI boot loader.
package boot_pkg;
    typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} boot_state_e;
    localparam int HDR_BYTES  = 6;
    localparam int SPI_ADDR_W = 24;
endpackage

// File: rtl/spi_boot_loader_sync_edge.sv
// N-stage pin synchroniser with a history flop for single-cycle rise/fall pulses.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign lvl_o  = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] & hist_q;
endmodule

// File: rtl/spi_boot_loader.sv
// Receives a 6-byte address header plus image bytes over SPI and streams them
// to the SRAM write arbiter; holds booting high until a full image has landed.
module spi_boot_loader
    import boot_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 18
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              arm_ss,
    input  logic              arm_sclk,
    input  logic              arm_mosi,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ack,
    output logic              booting,
    output logic              error,
    output logic              overrun
);
    localparam logic [2:0] LAST_HDR = 3'(HDR_BYTES - 1);

    logic ss_s, ss_rise, ss_fall;
    logic sclk_rise, sclk_fall_unused, sclk_lvl_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk100), .rst(reset), .d_i(arm_ss),
        .lvl_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .clk(clk100), .rst(reset), .d_i(arm_sclk),
        .lvl_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_mosi (
        .clk(clk100), .rst(reset), .d_i(arm_mosi),
        .lvl_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    boot_state_e            state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [SPI_ADDR_W-1:0]  start_q, start_d;
    logic [SPI_ADDR_W-1:0]  end_q, end_d;
    logic [SPI_ADDR_W-1:0]  addr_q, addr_d;
    logic                   wr_req_q, wr_req_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic                   booting_q, booting_d;
    logic                   error_q, error_d;
    logic                   overrun_q, overrun_d;

    logic                   byte_evt;
    logic [7:0]             byte_val;
    logic [SPI_ADDR_W-1:0]  end_full;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        start_d   = start_q;
        end_d     = end_q;
        addr_d    = addr_q;
        wr_req_d  = wr_req_q & ~wr_ack;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        booting_d = booting_q;
        error_d   = error_q;
        overrun_d = overrun_q;
        byte_evt  = 1'b0;
        byte_val  = {shreg_q[6:0], mosi_s};
        end_full  = {byte_val, end_q[15:0]};

        if (ss_fall) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (sclk_rise && !ss_s) begin
            shreg_d  = byte_val;
            cnt_d    = cnt_q + 3'd1;
            byte_evt = (cnt_q == 3'd7);
        end

        // ss rising takes priority over a byte completing in the same cycle
        if (ss_rise) begin
            case (state_q)
                HDR, DATA: begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
                DONE: begin
                    booting_d = 1'b0;
                    state_d   = IDLE;
                end
                default: ;
            endcase
        end else if (ss_fall) begin
            state_d = HDR;
            idx_d   = '0;
        end else if (byte_evt) begin
            case (state_q)
                HDR: begin
                    idx_d = idx_q + 3'd1;
                    case (idx_q)
                        3'd0: start_d[7:0]   = byte_val;
                        3'd1: start_d[15:8]  = byte_val;
                        3'd2: start_d[23:16] = byte_val;
                        3'd3: end_d[7:0]     = byte_val;
                        3'd4: end_d[15:8]    = byte_val;
                        default: ;
                    endcase
                    if (idx_q == LAST_HDR) begin
                        end_d   = end_full;
                        addr_d  = start_q;
                        state_d = (end_full < start_q) ? DONE : DATA;
                    end
                end
                DATA: begin
                    if (wr_req_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = addr_q[ADDR_W-1:0];
                        wr_data_d = byte_val;
                    end
                    // advance even on a drop so later bytes keep their addresses
                    addr_d = addr_q + 24'd1;
                    if (addr_q == end_q) state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            shreg_q   <= '0;
            start_q   <= '0;
            end_q     <= '0;
            addr_q    <= '0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            booting_q <= 1'b1;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            start_q   <= start_d;
            end_q     <= end_d;
            addr_q    <= addr_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            booting_q <= booting_d;
            error_q   <= error_d;
            overrun_q <= overrun_d;
        end
    end

    assign wr_req  = wr_req_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign booting = booting_q;
    assign error   = error_q;
    assign overrun = overrun_q;
endmodule

// File: tb/tb_spi_boot_loader.sv
// Directed bench: drives SPI image transfers and acks writes from a simple arbiter model.
module tb_spi_boot_loader;
    localparam int ADDR_W = 18;

    logic              clk100   = 1'b0;
    logic              reset    = 1'b1;
    logic              arm_ss   = 1'b1;
    logic              arm_sclk = 1'b1;
    logic              arm_mosi = 1'b1;
    logic              wr_ack   = 1'b0;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              booting, error, overrun;

    int checks = 0;
    int errors = 0;
    int ack_delay = 3;
    logic [ADDR_W-1:0] log_a[$];
    logic [7:0]        log_d[$];

    spi_boot_loader #(.SYNC_STAGES(2), .ADDR_W(ADDR_W)) dut (
        .clk100(clk100), .reset(reset),
        .arm_ss(arm_ss), .arm_sclk(arm_sclk), .arm_mosi(arm_mosi),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .booting(booting), .error(error), .overrun(overrun)
    );

    always #5 clk100 = ~clk100;

    // Arbiter model: log each request once, ack after ack_delay cycles.
    initial begin : arb
        bit seen;
        int n;
        seen = 1'b0;
        n = 0;
        forever begin
            @(negedge clk100);
            if (wr_req) begin
                if (!seen) begin
                    log_a.push_back(wr_addr);
                    log_d.push_back(wr_data);
                    seen = 1'b1;
                    n = 0;
                end
                n++;
                if (n >= ack_delay) wr_ack = 1'b1;
            end else begin
                seen = 1'b0;
                wr_ack = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            arm_sclk = 1'b0;
            arm_mosi = b[i];
            #25;
            arm_sclk = 1'b1;
            #25;
        end
    endtask

    task automatic ss_lo();
        arm_ss = 1'b0;
        #60;
    endtask

    task automatic ss_hi();
        #100;
        arm_ss = 1'b1;
        #200;
    endtask

    task automatic hdr(input logic [23:0] s, input logic [23:0] e);
        spi_byte(s[7:0]);  spi_byte(s[15:8]);  spi_byte(s[23:16]);
        spi_byte(e[7:0]);  spi_byte(e[15:8]);  spi_byte(e[23:16]);
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #40;
        reset = 1'b0;
        #40;
        clear_log();
    endtask

    task automatic full_image();
        ss_lo();
        hdr(24'h00C000, 24'h00C003);
        spi_byte(8'hA9); spi_byte(8'h00); spi_byte(8'h8D); spi_byte(8'hFF);
        #300;
    endtask

    logic [7:0] img [4];

    initial begin
        img[0] = 8'hA9; img[1] = 8'h00; img[2] = 8'h8D; img[3] = 8'hFF;
        #40;
        @(negedge clk100);
        check("rst_booting", 32'(booting), 32'd1);
        check("rst_wr_req",  32'(wr_req),  32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_error",   32'(error),   32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        #40;

        // truncated transfer after two data bytes
        ss_lo();
        hdr(24'h00C000, 24'h00C003);
        spi_byte(8'hA9); spi_byte(8'h00);
        #300;
        ss_hi();
        check("trunc_nwr",     32'(log_a.size()), 32'd2);
        check("trunc_a0",      32'(log_a[0]), 32'h0C000);
        check("trunc_d0",      32'(log_d[0]), 32'hA9);
        check("trunc_a1",      32'(log_a[1]), 32'h0C001);
        check("trunc_d1",      32'(log_d[1]), 32'h00);
        check("trunc_error",   32'(error),   32'd1);
        check("trunc_booting", 32'(booting), 32'd1);
        clear_log();
        full_image();
        check("retry_boot_pre", 32'(booting), 32'd1);
        ss_hi();
        check("retry_nwr",     32'(log_a.size()), 32'd4);
        check("retry_booting", 32'(booting), 32'd0);
        check("retry_error",   32'(error),   32'd1);

        // clean load
        do_reset();
        full_image();
        check("clean_boot_pre", 32'(booting), 32'd1);
        ss_hi();
        check("clean_nwr", 32'(log_a.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("clean_addr", 32'(log_a[i]), 32'h0C000 + 32'(i));
            check("clean_data", 32'(log_d[i]), 32'(img[i]));
        end
        check("clean_booting", 32'(booting), 32'd0);
        check("clean_error",   32'(error),   32'd0);
        check("clean_overrun", 32'(overrun), 32'd0);

        // slow arbiter: second byte dropped
        do_reset();
        ack_delay = 60;
        ss_lo();
        hdr(24'h000100, 24'h000102);
        spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33);
        #1000;
        ss_hi();
        ack_delay = 3;
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_nwr",  32'(log_a.size()), 32'd2);
        check("ovr_a0",   32'(log_a[0]), 32'h00100);
        check("ovr_d0",   32'(log_d[0]), 32'h11);
        check("ovr_a1",   32'(log_a[1]), 32'h00102);
        check("ovr_d1",   32'(log_d[1]), 32'h33);
        check("ovr_error", 32'(error), 32'd0);

        // end below start: empty image
        do_reset();
        ss_lo();
        hdr(24'h00C000, 24'h00BFFF);
        #200;
        check("empty_boot_pre", 32'(booting), 32'd1);
        ss_hi();
        check("empty_nwr",     32'(log_a.size()), 32'd0);
        check("empty_booting", 32'(booting), 32'd0);
        check("empty_error",   32'(error),   32'd0);

        // 18-bit address aliasing
        clear_log();
        ss_lo();
        hdr(24'h03FFFF, 24'h040000);
        spi_byte(8'h11); spi_byte(8'h22);
        #300;
        ss_hi();
        check("alias_nwr", 32'(log_a.size()), 32'd2);
        check("alias_a0",  32'(log_a[0]), 32'h3FFFF);
        check("alias_d0",  32'(log_d[0]), 32'h11);
        check("alias_a1",  32'(log_a[1]), 32'h00000);
        check("alias_d1",  32'(log_d[1]), 32'h22);
        check("alias_error", 32'(error), 32'd0);

        // reset while a write is pending in DATA
        ack_delay = 1000;
        ss_lo();
        hdr(24'h00C000, 24'h00C003);
        spi_byte(8'hA9);
        #100;
        check("mid_req_pending", 32'(wr_req), 32'd1);
        reset = 1'b1;
        #20;
        check("mid_wr_req",  32'(wr_req),  32'd0);
        check("mid_booting", 32'(booting), 32'd1);
        check("mid_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_wr_data", 32'(wr_data), 32'd0);
        check("mid_error",   32'(error),   32'd0);
        arm_ss = 1'b1;
        #40;
        reset = 1'b0;
        ack_delay = 3;
        #200;
        clear_log();
        full_image();
        ss_hi();
        check("post_nwr",     32'(log_a.size()), 32'd4);
        check("post_a3",      32'(log_a[3]), 32'h0C003);
        check("post_d3",      32'(log_d[3]), 32'hFF);
        check("post_booting", 32'(booting), 32'd0);
        check("post_error",   32'(error),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
